hs_tx_feeder: RTL and testbench
===============================

HS_TX_FEEDER -- requirements
Module: hs_tx_feeder

Interface
REQ-001 Parameter WIDTH, default 8, data word width; must match the downstream handshake synchronizer's WIDTH.
REQ-002 Parameter DEPTH, default 8, FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  single clock (clk1 domain); all logic rising-edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_data  input  WIDTH  upstream word.
REQ-007 in_ready  output  1  high when FIFO not full; a word is accepted on any edge with in_valid&in_ready.
REQ-008 sidle  input  1  idle indication from the handshake synchronizer.
REQ-009 sready  output  1  registered one-cycle load pulse to the synchronizer.
REQ-010 din  output  WIDTH  registered word presented with sready.
REQ-011 busy  output  1  high when FIFO non-empty or FSM not IDLE.
REQ-012 tx_cnt  output  16  count of words issued since reset.

Function
REQ-013 The FIFO SHALL store accepted words in arrival order and issue them in that order.
REQ-014 in_ready SHALL be !full, derived combinationally from the stored count; a push while full SHALL never occur.
REQ-015 The FSM SHALL use four states: IDLE, SEND, WAIT_LOW and WAIT_HIGH.
REQ-016 IDLE->SEND SHALL occur when FIFO non-empty and sidle==1. At that edge the FIFO head is popped into din, sready<=1 and tx_cnt increments.
REQ-017 In IDLE with an empty FIFO or sidle==0, the FSM SHALL remain in IDLE.
REQ-018 SEND SHALL last exactly one cycle, then go to WAIT_LOW; sready SHALL clear at that edge, giving a 1-cycle pulse.
REQ-019 WAIT_LOW SHALL hold until sidle==0, then go to WAIT_HIGH.
REQ-020 WAIT_HIGH SHALL hold until sidle==1, then go to IDLE.
REQ-021 At most one sready pulse SHALL be issued per sidle low/high cycle.
REQ-022 din SHALL hold its last value until the next pop; it SHALL never change while in WAIT_LOW or WAIT_HIGH.
REQ-023 Simultaneous push and pop SHALL leave the count unchanged and preserve order, including a push at count 1 coinciding with the pop.
REQ-024 FIFO read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by a separate count of width log2(DEPTH)+1.
REQ-025 tx_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-026 Minimum spacing between sready pulses SHALL be 4 cycles (SEND, WAIT_LOW, WAIT_HIGH, IDLE).

Reset
REQ-027 Reset SHALL drive sready=0, din=0, tx_cnt=0 and FSM=IDLE, and SHALL empty the FIFO (pointers and count 0); in_ready=1 and busy=0 follow.
REQ-028 Reset asserted in any state, including mid-handshake, SHALL discard all queued words; no sready SHALL follow until a new word is accepted.

Structure
REQ-029 Shared package SHALL hold the FSM state enum (2 bits) and default WIDTH/DEPTH constants.
REQ-030 The FIFO SHALL be one sub-module, sync_fifo (push, pop, dout, full, empty, count), instantiated once.

Verification
REQ-031 Reset: assert rst mid-run -> sready=0, din=0x00, tx_cnt=0, in_ready=1, busy=0.
REQ-032 Single word: push 0xA5, sidle=1; sidle model drops 1 cycle after the pulse and rises 6 cycles later -> exactly one sready pulse with din=0xA5, tx_cnt=1, busy low after return to IDLE.
REQ-033 Fill: sidle held 0, push 10 words 0x01..0x0A -> first 8 accepted, in_ready=0 after the 8th, no sready.
REQ-034 Order: continuing from REQ-033, release sidle and keep pushing 0x09..0x0A -> din sequence 0x01..0x0A, 10 pulses, tx_cnt=10, pulse spacing >=4 cycles.
REQ-035 Mid-handshake reset: rst during WAIT_HIGH with 3 queued words -> FIFO empty, state IDLE, no further sready after rst deasserts.
REQ-036 Push/pop collision: with count 1 and sidle=1, push 0x5A in the pop cycle -> count stays 1, next issued word is 0x5A.

Source files
------------

// File: rtl/hs_tx_feeder_pkg.sv
// Shared types and defaults for the handshake transmit feeder.
// Holds the feeder FSM encoding and the default word width / FIFO depth.
package hs_tx_feeder_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_LOW  = 2'd2,
        ST_WAIT_HIGH = 2'd3
    } state_t;

endpackage

// File: rtl/hs_tx_feeder_sync_fifo.sv
// Single-clock show-ahead FIFO: dout always presents the oldest stored word.
// Pointers wrap modulo DEPTH; a separate count tells full from empty.
import hs_tx_feeder_pkg::*;

module sync_fifo #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Guard against overflow/underflow even if a caller misbehaves.
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == CW'(0));
    assign count = count_r;
    assign dout  = mem_r[rd_ptr_r];

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= AW'(1'b0);
            rd_ptr_r <= AW'(1'b0);
            count_r  <= CW'(1'b0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/hs_tx_feeder.sv
// Feeds queued words to a handshake synchronizer, one sready pulse per
// sidle low/high round trip, with din held stable between pops.
import hs_tx_feeder_pkg::*;

module hs_tx_feeder #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             sidle,
    output logic             sready,
    output logic [WIDTH-1:0] din,
    output logic             busy,
    output logic [15:0]      tx_cnt
);

    state_t                  state_r;
    state_t                  next_state_s;
    logic                    push_s;
    logic                    pop_s;
    logic [WIDTH-1:0]        fifo_dout_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [$clog2(DEPTH):0]  fifo_count_s;
    logic                    sready_r;
    logic [WIDTH-1:0]        din_r;
    logic [15:0]             tx_cnt_r;

    assign push_s   = in_valid & ~fifo_full_s;
    assign in_ready = ~fifo_full_s;
    assign busy     = ~fifo_empty_s | (state_r != ST_IDLE);
    assign sready   = sready_r;
    assign din      = din_r;
    assign tx_cnt   = tx_cnt_r;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (in_data),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Handshake sequencing: a pop only ever happens from IDLE.
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s && sidle) begin
                    next_state_s = ST_SEND;
                    pop_s        = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                next_state_s = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!sidle) begin
                    next_state_s = ST_WAIT_HIGH;
                end else begin
                    next_state_s = ST_WAIT_LOW;
                end
            end
            ST_WAIT_HIGH: begin
                if (sidle) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WAIT_HIGH;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                pop_s        = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered load pulse, held data word and issue counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sready_r <= 1'b0;
            din_r    <= {WIDTH{1'b0}};
            tx_cnt_r <= 16'h0000;
        end else if (pop_s) begin
            sready_r <= 1'b1;
            din_r    <= fifo_dout_s;
            tx_cnt_r <= tx_cnt_r + 16'h0001;
        end else begin
            sready_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hs_tx_feeder.sv
// Self-checking bench for hs_tx_feeder: scoreboard of accepted words against
// words observed with sready, plus a behavioural sidle responder.
module tb_hs_tx_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        sidle;
    logic        sready;
    logic [7:0]  din;
    logic        busy;
    logic [15:0] tx_cnt;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         obs_cyc_q[$];
    int         cyc = 0;
    int         pulse_cnt = 0;
    int         long_pulse = 0;
    bit         model_en = 1'b0;
    bit         sidle_ovr = 1'b1;

    hs_tx_feeder #(.WIDTH(8), .DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .sidle    (sidle),
        .sready   (sready),
        .din      (din),
        .busy     (busy),
        .tx_cnt   (tx_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: record every sready pulse with its data word and cycle.
    initial begin
        bit prev;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sready === 1'b1) begin
                obs_q.push_back(din);
                obs_cyc_q.push_back(cyc);
                pulse_cnt++;
                if (prev) long_pulse++;
            end
            prev = (sready === 1'b1);
        end
    end

    // sidle responder: drops one cycle after a pulse, rises six cycles later.
    initial begin
        int st;
        int cnt;
        st = 0;
        cnt = 0;
        sidle = 1'b1;
        forever begin
            @(negedge clk);
            if (!model_en) begin
                sidle = sidle_ovr;
                st = 0;
            end else begin
                case (st)
                    0: begin
                        sidle = 1'b1;
                        if (sready === 1'b1) st = 1;
                    end
                    1: begin
                        sidle = 1'b0;
                        cnt = 6;
                        st = 2;
                    end
                    default: begin
                        cnt--;
                        if (cnt == 0) begin
                            sidle = 1'b1;
                            st = 0;
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tick(2);
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        obs_cyc_q.delete();
        pulse_cnt = 0;
        long_pulse = 0;
        tick(1);
    endtask

    task automatic try_push(input logic [7:0] d, output bit acc);
        acc = in_ready;
        in_valid = 1'b1;
        in_data = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (acc) exp_q.push_back(d);
    endtask

    task automatic test_reset();
        bit acc;
        model_en = 1'b1;
        do_reset();
        try_push(8'h33, acc);
        try_push(8'h44, acc);
        tick(4);
        n_chk++; if (pulse_cnt !== 1) $display("FAIL reset_prerun_pulses: got %0d want 1", pulse_cnt); else n_pass++;
        n_chk++; if (din !== 8'h33) $display("FAIL reset_prerun_din: got %h want 33", din); else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++; if (sready !== 1'b0) $display("FAIL reset_sready: got %b want 0", sready); else n_pass++;
        n_chk++; if (din !== 8'h00) $display("FAIL reset_din: got %h want 00", din); else n_pass++;
        n_chk++; if (tx_cnt !== 16'h0000) $display("FAIL reset_tx_cnt: got %h want 0000", tx_cnt); else n_pass++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        model_en = 1'b0;
        sidle_ovr = 1'b1;
        do_reset();
    endtask

    task automatic test_single();
        bit acc;
        logic [7:0] e;
        logic [7:0] o;
        model_en = 1'b1;
        do_reset();
        try_push(8'hA5, acc);
        for (int i = 0; i < 30 && obs_q.size() == 0; i++) tick(1);
        n_chk++;
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            $display("FAIL single_timeout: got no pulse within 30 cycles, want one");
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o !== e) $display("FAIL single_din: got %h want %h", o, e); else n_pass++;
        end
        tick(15);
        n_chk++; if (pulse_cnt !== 1) $display("FAIL single_pulses: got %0d want 1", pulse_cnt); else n_pass++;
        n_chk++; if (tx_cnt !== 16'd1) $display("FAIL single_tx_cnt: got %0d want 1", tx_cnt); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL single_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (din !== 8'hA5) $display("FAIL single_din_hold: got %h want a5", din); else n_pass++;
        n_chk++; if (long_pulse !== 0) $display("FAIL single_pulse_width: got %0d long pulses want 0", long_pulse); else n_pass++;
    endtask

    task automatic test_fill_order();
        bit acc;
        int acc_cnt;
        int bad_sp;
        int bad_d;
        bit ok;
        logic [7:0] e;
        logic [7:0] o;
        model_en = 1'b0;
        sidle_ovr = 1'b0;
        do_reset();
        acc_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            try_push(8'(i), acc);
            if (acc) acc_cnt++;
            if (i == 8) begin
                n_chk++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b want 0", in_ready); else n_pass++;
            end
        end
        n_chk++; if (acc_cnt !== 8) $display("FAIL fill_accepted: got %0d want 8", acc_cnt); else n_pass++;
        n_chk++; if (pulse_cnt !== 0) $display("FAIL fill_no_pulse: got %0d want 0", pulse_cnt); else n_pass++;
        model_en = 1'b1;
        for (int w = 9; w <= 10; w++) begin
            ok = 1'b0;
            for (int t = 0; t < 200 && !ok; t++) begin
                try_push(8'(w), acc);
                ok = acc;
            end
            n_chk++; if (!ok) $display("FAIL order_push_%0d: got not accepted want accepted", w); else n_pass++;
        end
        for (int i = 0; i < 300 && obs_q.size() < 10; i++) tick(1);
        n_chk++; if (pulse_cnt !== 10) $display("FAIL order_pulses: got %0d want 10", pulse_cnt); else n_pass++;
        bad_d = 0;
        for (int i = 0; i < 10 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o !== e || o !== 8'(i + 1)) begin
                bad_d++;
                $display("FAIL order_din_%0d: got %h want %h", i, o, 8'(i + 1));
            end
        end
        n_chk++; if (bad_d != 0) $display("FAIL order_sequence: got %0d bad words want 0", bad_d); else n_pass++;
        bad_sp = 0;
        for (int i = 1; i < obs_cyc_q.size(); i++) begin
            if (obs_cyc_q[i] - obs_cyc_q[i-1] < 4) bad_sp++;
        end
        n_chk++; if (bad_sp != 0) $display("FAIL order_spacing: got %0d short gaps want 0", bad_sp); else n_pass++;
        tick(12);
        n_chk++; if (tx_cnt !== 16'd10) $display("FAIL order_tx_cnt: got %0d want 10", tx_cnt); else n_pass++;
        n_chk++; if (long_pulse !== 0) $display("FAIL order_pulse_width: got %0d long pulses want 0", long_pulse); else n_pass++;
    endtask

    task automatic test_mid_reset();
        bit acc;
        int pc;
        logic [7:0] o;
        model_en = 1'b0;
        sidle_ovr = 1'b0;
        do_reset();
        try_push(8'h21, acc);
        try_push(8'h22, acc);
        try_push(8'h23, acc);
        try_push(8'h24, acc);
        sidle_ovr = 1'b1;
        for (int i = 0; i < 10 && obs_q.size() == 0; i++) tick(1);
        n_chk++;
        if (obs_q.size() == 0) begin
            $display("FAIL midrst_first_timeout: got no pulse want one");
        end else begin
            o = obs_q.pop_front();
            if (o !== 8'h21) $display("FAIL midrst_first_din: got %h want 21", o); else n_pass++;
        end
        tick(2);
        sidle_ovr = 1'b0;
        tick(3);
        n_chk++; if (dut.state_r !== 2'd3) $display("FAIL midrst_in_wait_high: got %0d want 3", dut.state_r); else n_pass++;
        n_chk++; if (dut.fifo_count_s !== 4'd3) $display("FAIL midrst_queued: got %0d want 3", dut.fifo_count_s); else n_pass++;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_q.delete();
        pc = pulse_cnt;
        sidle_ovr = 1'b1;
        tick(20);
        n_chk++; if (pulse_cnt !== pc) $display("FAIL midrst_no_pulse: got %0d pulses want %0d", pulse_cnt, pc); else n_pass++;
        n_chk++; if (dut.fifo_count_s !== 4'd0) $display("FAIL midrst_fifo_empty: got %0d want 0", dut.fifo_count_s); else n_pass++;
        n_chk++; if (dut.state_r !== 2'd0) $display("FAIL midrst_state: got %0d want 0", dut.state_r); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (tx_cnt !== 16'd0) $display("FAIL midrst_tx_cnt: got %0d want 0", tx_cnt); else n_pass++;
    endtask

    task automatic test_collision();
        bit acc;
        logic [7:0] e;
        logic [7:0] o;
        int bad;
        model_en = 1'b0;
        sidle_ovr = 1'b0;
        do_reset();
        try_push(8'h11, acc);
        tick(1);
        n_chk++; if (dut.fifo_count_s !== 4'd1) $display("FAIL coll_pre_count: got %0d want 1", dut.fifo_count_s); else n_pass++;
        sidle_ovr = 1'b1;
        try_push(8'h5A, acc);
        n_chk++; if (sready !== 1'b1) $display("FAIL coll_pop_same_edge: got sready %b want 1", sready); else n_pass++;
        n_chk++; if (dut.fifo_count_s !== 4'd1) $display("FAIL coll_count: got %0d want 1", dut.fifo_count_s); else n_pass++;
        tick(2);
        sidle_ovr = 1'b0;
        tick(3);
        sidle_ovr = 1'b1;
        for (int i = 0; i < 20 && obs_q.size() < 2; i++) tick(1);
        n_chk++; if (obs_q.size() !== 2) $display("FAIL coll_pulses: got %0d want 2", obs_q.size()); else n_pass++;
        bad = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o !== e) begin
                bad++;
                $display("FAIL coll_din: got %h want %h", o, e);
            end
        end
        n_chk++; if (bad != 0 || exp_q.size() != 0) $display("FAIL coll_order: got %0d bad, %0d left want 0, 0", bad, exp_q.size()); else n_pass++;
        n_chk++; if (din !== 8'h5A) $display("FAIL coll_last_din: got %h want 5a", din); else n_pass++;
        n_chk++; if (tx_cnt !== 16'd2) $display("FAIL coll_tx_cnt: got %0d want 2", tx_cnt); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        tick(3);
        rst = 1'b0;
        tick(2);
        test_reset();
        test_single();
        test_fill_order();
        test_mid_reset();
        test_collision();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
